// File: rtl/ipml_fifo_mc_pkg.sv
// Shared sizing helpers for the multi-channel FIFO controller.
package ipml_fifo_mc_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'(1) << r) < v) r = r + 1;
        return r;
    endfunction

    // Channel-select width; a single channel still needs one select bit.
    function automatic int unsigned ch_width(input int unsigned ch_num);
        return (clog2(ch_num) < 1) ? 1 : clog2(ch_num);
    endfunction

    // Occupancy needs one bit beyond the pointer to represent a full channel.
    function automatic int unsigned lvl_width(input int unsigned depth_width);
        return depth_width + 1;
    endfunction

    function automatic int unsigned wl_lsb(input int unsigned ch, input int unsigned depth_width);
        return ch * lvl_width(depth_width);
    endfunction

endpackage

// File: rtl/ipml_fifo_mc_ctrl_if.sv
// Request/accept/address handshake between a client and the multi-channel FIFO controller.
interface ipml_fifo_mc_ctrl_if
    import ipml_fifo_mc_pkg::*;
#(
    parameter int unsigned c_CH_NUM      = 4,
    parameter int unsigned c_DEPTH_WIDTH = 9
);
    localparam int unsigned CW = ch_width(c_CH_NUM);
    localparam int unsigned AW = CW + c_DEPTH_WIDTH;

    logic          w_en;
    logic [CW-1:0] w_ch;
    logic [AW-1:0] waddr;
    logic          wr_accept;
    logic          r_en;
    logic [CW-1:0] r_ch;
    logic [AW-1:0] raddr;
    logic          rd_accept;

    modport master (output w_en, w_ch, r_en, r_ch,
                    input  waddr, wr_accept, raddr, rd_accept);
    modport slave  (input  w_en, w_ch, r_en, r_ch,
                    output waddr, wr_accept, raddr, rd_accept);
endinterface

// File: rtl/ipml_fifo_mc_ch.sv
// One channel's pointers, occupancy and flags; sticky errors exist only with FIFO_MC_ERR_EN.
module ipml_fifo_mc_ch
    import ipml_fifo_mc_pkg::*;
#(
    parameter int unsigned c_DEPTH_WIDTH      = 9,
    parameter int unsigned c_ALMOST_FULL_NUM  = 508,
    parameter int unsigned c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_acc,
    input  logic                                rd_acc,
    input  logic                                flush,
    input  logic                                err_clr,
    input  logic                                ovf_set,
    input  logic                                udf_set,
    output logic [c_DEPTH_WIDTH-1:0]            wptr,
    output logic [c_DEPTH_WIDTH-1:0]            rptr,
    output logic [lvl_width(c_DEPTH_WIDTH)-1:0] level,
    output logic                                wfull,
    output logic                                almost_full,
    output logic                                rempty,
    output logic                                almost_empty,
    output logic                                overflow,
    output logic                                underflow
);
    localparam int unsigned DW = c_DEPTH_WIDTH;
    localparam int unsigned LW = lvl_width(c_DEPTH_WIDTH);
    localparam int unsigned D  = 32'(1) << DW;

    logic [LW-1:0] cnt_nxt_c;

    always_comb begin
        cnt_nxt_c = level;
        if (flush) cnt_nxt_c = '0;
        else       cnt_nxt_c = level + LW'(wr_acc) - LW'(rd_acc);
    end

    // Flags are registered from the next count so they track the access with no lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
            wfull        <= 1'b0;
            almost_full  <= 1'b0;
            rempty       <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + DW'(1);
                if (rd_acc) rptr <= rptr + DW'(1);
            end
            level        <= cnt_nxt_c;
            wfull        <= (cnt_nxt_c == LW'(D));
            rempty       <= (cnt_nxt_c == '0);
            almost_full  <= (cnt_nxt_c >= LW'(c_ALMOST_FULL_NUM));
            almost_empty <= (cnt_nxt_c <= LW'(c_ALMOST_EMPTY_NUM));
        end
    end

`ifdef FIFO_MC_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_set) overflow  <= 1'b1;
            if (udf_set) underflow <= 1'b1;
        end
    end
`else
    logic unused_err;
    assign unused_err = &{1'b0, err_clr, ovf_set, udf_set};
    assign overflow   = 1'b0;
    assign underflow  = 1'b0;
`endif

endmodule

// File: rtl/ipml_fifo_mc_ctrl.sv
// Multi-channel FIFO controller over one shared SDP RAM addressed {channel, pointer}.
// Optional sticky overflow/underflow flags are built when FIFO_MC_ERR_EN is defined.
module ipml_fifo_mc_ctrl
    import ipml_fifo_mc_pkg::*;
#(
    parameter int unsigned c_CH_NUM           = 4,
    parameter int unsigned c_DEPTH_WIDTH      = 9,
    parameter int unsigned c_ALMOST_FULL_NUM  = 508,
    parameter int unsigned c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    ipml_fifo_mc_ctrl_if.slave                           bus,
    input  logic [c_CH_NUM-1:0]                          ch_flush,
    output logic [c_CH_NUM-1:0]                          wfull,
    output logic [c_CH_NUM-1:0]                          almost_full,
    output logic [c_CH_NUM-1:0]                          rempty,
    output logic [c_CH_NUM-1:0]                          almost_empty,
    output logic [c_CH_NUM*lvl_width(c_DEPTH_WIDTH)-1:0] water_level,
    input  logic                                         err_clr,
    output logic [c_CH_NUM-1:0]                          overflow,
    output logic [c_CH_NUM-1:0]                          underflow
);
    localparam int unsigned CW  = ch_width(c_CH_NUM);
    localparam int unsigned DW  = c_DEPTH_WIDTH;
    localparam int unsigned LW  = lvl_width(c_DEPTH_WIDTH);
    localparam int unsigned NP2 = 32'(1) << CW;

    // Padded to the full select range so an out-of-range select never indexes past the array.
    logic [NP2-1:0] wfull_p;
    logic [NP2-1:0] rempty_p;
    logic [DW-1:0]  wptr_a [NP2];
    logic [DW-1:0]  rptr_a [NP2];
    logic           w_ch_ok_c;
    logic           r_ch_ok_c;

    assign wfull_p   = NP2'(wfull);
    assign rempty_p  = NP2'(rempty);
    assign w_ch_ok_c = (32'(bus.w_ch) < c_CH_NUM);
    assign r_ch_ok_c = (32'(bus.r_ch) < c_CH_NUM);

    assign bus.wr_accept = bus.w_en & w_ch_ok_c & ~wfull_p[bus.w_ch];
    assign bus.rd_accept = bus.r_en & r_ch_ok_c & ~rempty_p[bus.r_ch];
    assign bus.waddr     = {bus.w_ch, wptr_a[bus.w_ch]};
    assign bus.raddr     = {bus.r_ch, rptr_a[bus.r_ch]};

    for (genvar c = 0; c < NP2; c++) begin : g_ch
        if (c < c_CH_NUM) begin : g_act
            logic w_hit_c;
            logic r_hit_c;
            assign w_hit_c = (bus.w_ch == CW'(c));
            assign r_hit_c = (bus.r_ch == CW'(c));

            ipml_fifo_mc_ch #(
                .c_DEPTH_WIDTH      (c_DEPTH_WIDTH),
                .c_ALMOST_FULL_NUM  (c_ALMOST_FULL_NUM),
                .c_ALMOST_EMPTY_NUM (c_ALMOST_EMPTY_NUM)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_n),
                .wr_acc       (bus.wr_accept & w_hit_c),
                .rd_acc       (bus.rd_accept & r_hit_c),
                .flush        (ch_flush[c]),
                .err_clr      (err_clr),
                .ovf_set      (bus.w_en & w_hit_c & wfull[c]),
                .udf_set      (bus.r_en & r_hit_c & rempty[c]),
                .wptr         (wptr_a[c]),
                .rptr         (rptr_a[c]),
                .level        (water_level[wl_lsb(c, DW) +: LW]),
                .wfull        (wfull[c]),
                .almost_full  (almost_full[c]),
                .rempty       (rempty[c]),
                .almost_empty (almost_empty[c]),
                .overflow     (overflow[c]),
                .underflow    (underflow[c])
            );
        end else begin : g_pad
            assign wptr_a[c] = '0;
            assign rptr_a[c] = '0;
        end
    end

endmodule

// File: doc/ipml_fifo_mc_ctrl.md
Name: ipml_fifo_mc_ctrl

Overview:
- Synchronous multi-channel FIFO controller for one shared simple-dual-port RAM of c_CH_NUM*2^c_DEPTH_WIDTH words.
- The RAM is statically partitioned into equal per-channel regions, addressed {channel, pointer}.
- Each channel keeps its own pointers, occupancy count, full/empty/almost flags and water level.
- Sits in front of the frame/line buffers where several streams share one block RAM on a single clock.

Parameters:
c_CH_NUM, 4, number of channels (2..16).
c_DEPTH_WIDTH, 9, per-channel address width; channel depth D = 2^c_DEPTH_WIDTH (4..12).
c_ALMOST_FULL_NUM, 508, almost_full[c] asserted when level >= this (1..D).
c_ALMOST_EMPTY_NUM, 4, almost_empty[c] asserted when level <= this (0..D-1).
Local: CW = clog2(c_CH_NUM), minimum 1.

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous active-low reset. This is fixed: one clock, reset asynchronous and active-low.
w_en  in  1  write request.
w_ch  in  CW  write channel select.
waddr  out  CW+c_DEPTH_WIDTH  RAM write address {w_ch, wptr[w_ch]}, combinational.
wr_accept  out  1  write accepted this cycle; drives RAM write enable.
r_en  in  1  read request.
r_ch  in  CW  read channel select.
raddr  out  CW+c_DEPTH_WIDTH  RAM read address {r_ch, rptr[r_ch]}, combinational.
rd_accept  out  1  read accepted this cycle.
ch_flush  in  c_CH_NUM  per-channel synchronous flush.
wfull  out  c_CH_NUM  per-channel full.
almost_full  out  c_CH_NUM  per-channel almost full.
rempty  out  c_CH_NUM  per-channel empty.
almost_empty  out  c_CH_NUM  per-channel almost empty.
water_level  out  c_CH_NUM*(c_DEPTH_WIDTH+1)  packed per-channel occupancy, channel c at bits [c*(DW+1) +: DW+1].
err_clr  in  1  clears the sticky error flags.
overflow  out  c_CH_NUM  sticky: write attempted while the channel was full.
underflow  out  c_CH_NUM  sticky: read attempted while the channel was empty.

Behaviour:
- Reset values:
  - pointers, counts, water_level, wfull, almost_full, overflow, underflow: 0.
  - rempty: all 1; almost_empty: all 1.
- Accept rules:
  - wr_accept = w_en & ~wfull[w_ch].
  - rd_accept = r_en & ~rempty[r_ch].
  - Both accept signals use the registered flags.
- Pointers:
  - Binary, c_DEPTH_WIDTH bits, wrap naturally from D-1 to 0.
  - An accepted write advances wptr[w_ch]; an accepted read advances rptr[r_ch].
- Count:
  - Per-channel count is c_DEPTH_WIDTH+1 bits.
  - cnt_next = cnt + wr_acc_c - rd_acc_c.
  - A simultaneous read and write on the same channel leaves the count unchanged.
- Flags: registered from cnt_next, so they are valid the cycle after the causing access (no extra latency).
  - wfull = (cnt_next == D).
  - rempty = (cnt_next == 0).
  - almost_full = (cnt_next >= c_ALMOST_FULL_NUM).
  - almost_empty = (cnt_next <= c_ALMOST_EMPTY_NUM).
  - water_level = cnt_next.
- Boundary cases:
  - Full channel, simultaneous write and read on it: write is rejected, read proceeds, count becomes D-1.
  - Empty channel, simultaneous write and read on it: read is rejected, write proceeds, count becomes 1.
  - Reads and writes on different channels are fully independent in the same cycle.
- Flush:
  - ch_flush[c] zeroes wptr, rptr and count of channel c at the next edge: rempty=1, wfull=0, level=0.
  - Flush overrides any accept on channel c in that cycle. wr_accept/rd_accept still assert (RAM write is harmless), but the pointers do not move.
- Out-of-range select: a channel select >= c_CH_NUM forces the matching accept signal to 0 and is treated as a rejected request.
- Asynchronous reset mid-operation returns every register to its reset value immediately. No partial state survives.

Optional Feature:
FIFO_MC_ERR_EN
- Defined:
  - overflow[c] sets on w_en with w_ch==c while wfull[c].
  - underflow[c] sets on r_en with r_ch==c while rempty[c].
  - Both hold until err_clr.
  - err_clr has priority over a set in the same cycle.
- Not defined: overflow and underflow are tied to 0 and err_clr is ignored.

Decomposition:
- Package ipml_fifo_mc_pkg holds:
  - clog2 function.
  - CW derivation.
  - level-width constant.
  - water-level slice index function.
- Sub-module ipml_fifo_mc_ch holds one channel's wptr, rptr, count, flags and error bits.
  - Inputs: wr_acc, rd_acc, flush, err_clr.
  - Instanced c_CH_NUM times in a generate loop.
- The top level does select decoding and address muxing.

Test Plan:
(Runs with c_CH_NUM=4, c_DEPTH_WIDTH=4 (D=16), AF=14, AE=2.)
- Reset release -> rempty=4'b1111, almost_empty=4'b1111, wfull=0, water_level=0, waddr=raddr=0.
- 16 writes to ch2, then a 17th -> wfull[2]=1 after the 16th; the 17th gives wr_accept=0 and sets overflow[2] (macro on); level[2]=16; almost_full[2] from the 14th write.
- ch2 full, w_en and r_en on ch2 in the same cycle -> read accepted, write rejected, level[2]=15, wfull[2]=0 the next cycle.
- Write ch0 and read ch1 (ch1 holding 3) in the same cycle -> level[0]=1, level[1]=2, almost_empty[1]=1; other channels unchanged.
- Write 20 and read 20 interleaved on ch3 -> the pointer wraps 15 to 0; raddr follows {2'd3, 4'd0..}; data order is preserved against the RAM model.
- ch_flush[1] asserted while ch1 holds 5 and a write to ch1 arrives in the same cycle -> level[1]=0, rempty[1]=1, pointers 0; reading an empty channel then sets underflow[1]; err_clr clears it.
